// File: rtl/hazard_pkg.sv
// Shared pipeline-control types: stage-select codes and hazard FSM states.
// Imported by the hazard unit and the pipeline registers that consume its selects.
package hazard_pkg;

    typedef enum logic [1:0] {
        SEL_RUN   = 2'b00,
        SEL_HOLD  = 2'b01,
        SEL_CLEAR = 2'b11
    } sel_e;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_en;
        sel_e if_id;
        sel_e id_ex;
        sel_e ex_mem;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN      = '{pc_en: 1'b1, if_id: SEL_RUN,   id_ex: SEL_RUN,   ex_mem: SEL_RUN};
    localparam ctrl_t CTRL_RESET    = '{pc_en: 1'b0, if_id: SEL_CLEAR, id_ex: SEL_CLEAR, ex_mem: SEL_CLEAR};
    localparam ctrl_t CTRL_MEMSTALL = '{pc_en: 1'b0, if_id: SEL_HOLD,  id_ex: SEL_HOLD,  ex_mem: SEL_HOLD};
    localparam ctrl_t CTRL_BRANCH   = '{pc_en: 1'b1, if_id: SEL_CLEAR, id_ex: SEL_CLEAR, ex_mem: SEL_RUN};
    localparam ctrl_t CTRL_LOADUSE  = '{pc_en: 1'b0, if_id: SEL_HOLD,  id_ex: SEL_CLEAR, ex_mem: SEL_RUN};

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit control bundle: ID/EX/MEM hazard sources in, PC enable and
// stage selects out. The pipeline side is the master, the hazard unit the slave.
interface hazard_unit_if;
    import hazard_pkg::*;

    logic [4:0] id_rs1_addr_i;
    logic [4:0] id_rs2_addr_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic       id_rs1_f_i;
    logic       id_rs2_f_i;
    logic [4:0] ex_rd_addr_i;
    logic       ex_rd_wren_I_i;
    logic       ex_rd_wren_F_i;
    logic       ex_is_load_i;
    logic       ex_br_taken_i;
    logic       mem_req_i;
    logic       mem_ack_i;
    logic       pc_en_o;
    sel_e       if_id_sel_o;
    sel_e       id_ex_sel_o;
    sel_e       ex_mem_sel_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        output id_rs1_f_i, id_rs2_f_i, ex_rd_addr_i, ex_rd_wren_I_i, ex_rd_wren_F_i,
        output ex_is_load_i, ex_br_taken_i, mem_req_i, mem_ack_i,
        input  pc_en_o, if_id_sel_o, id_ex_sel_o, ex_mem_sel_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        input  id_rs1_f_i, id_rs2_f_i, ex_rd_addr_i, ex_rd_wren_I_i, ex_rd_wren_F_i,
        input  ex_is_load_i, ex_br_taken_i, mem_req_i, mem_ack_i,
        output pc_en_o, if_id_sel_o, id_ex_sel_o, ex_mem_sel_o
    );

endinterface

// File: rtl/hazard_load_use.sv
// Combinational load-use detector: a load in EX whose destination is read by the ID
// instruction, for either source and either register file.
module hazard_load_use (
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic       rs1_f_i,
    input  logic       rs2_f_i,
    input  logic [4:0] rd_addr_i,
    input  logic       rd_wren_int_i,
    input  logic       rd_wren_fp_i,
    input  logic       is_load_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired zero so never a real dependency; f0 is an ordinary FP register.
    always_comb begin
        rs1_hit = rs1_used_i && (rs1_addr_i == rd_addr_i) &&
                  ((!rs1_f_i && rd_wren_int_i && (rd_addr_i != 5'd0)) ||
                   ( rs1_f_i && rd_wren_fp_i));
        rs2_hit = rs2_used_i && (rs2_addr_i == rd_addr_i) &&
                  ((!rs2_f_i && rd_wren_int_i && (rd_addr_i != 5'd0)) ||
                   ( rs2_f_i && rd_wren_fp_i));
        load_use_o = is_load_i && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: prioritised MEM-wait / branch-flush / load-use selects,
// MEM-wait FSM with bounded timeout, and stall/flush performance counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    hazard_unit_if.slave     hz,
    output logic             err_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic  [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;
    logic  [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic  load_use;
    logic  timeout_hit;
    logic  mem_stall;
    logic  branch;
    ctrl_t ctrl;

    hazard_load_use u_load_use (
        .rs1_addr_i    (hz.id_rs1_addr_i),
        .rs2_addr_i    (hz.id_rs2_addr_i),
        .rs1_used_i    (hz.id_rs1_used_i),
        .rs2_used_i    (hz.id_rs2_used_i),
        .rs1_f_i       (hz.id_rs1_f_i),
        .rs2_f_i       (hz.id_rs2_f_i),
        .rd_addr_i     (hz.ex_rd_addr_i),
        .rd_wren_int_i (hz.ex_rd_wren_I_i),
        .rd_wren_fp_i  (hz.ex_rd_wren_F_i),
        .is_load_i     (hz.ex_is_load_i),
        .load_use_o    (load_use)
    );

    // On the last permitted wait cycle the pipe is released as if the access had completed.
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST);
    assign mem_stall   = hz.mem_req_i && !hz.mem_ack_i && !timeout_hit;
    assign branch      = hz.ex_br_taken_i;

    always_comb begin
        ctrl = CTRL_RUN;
        if (i_rst) begin
            ctrl = CTRL_RESET;
        end else if (mem_stall) begin
            ctrl = CTRL_MEMSTALL;
        end else if (branch) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOADUSE;
        end
    end

    assign hz.pc_en_o      = ctrl.pc_en;
    assign hz.if_id_sel_o  = ctrl.if_id;
    assign hz.id_ex_sel_o  = ctrl.id_ex;
    assign hz.ex_mem_sel_o = ctrl.ex_mem;

    always_comb begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
        err_d      = hz.mem_req_i && !hz.mem_ack_i && timeout_hit;
        if (mem_stall) begin
            state_d    = S_WAIT;
            wait_cnt_d = (state_q == S_RUN) ? WAIT_W'(1) : wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            if (!ctrl.pc_en) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (branch && !mem_stall) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign err_timeout_o = err_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (TIMEOUT=4): load-use, branch flush, MEM wait, timeout, reset.
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 32;

    logic             i_clk;
    logic             i_rst;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_tests;
    int n_fail;

    hazard_unit_if hif ();

    hazard_unit #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .hz            (hif.slave),
        .err_timeout_o (err_timeout),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic pc, input sel_e a, input sel_e b,
                              input sel_e c);
        check({tag, ".pc_en"},  32'(hif.pc_en_o),      32'(pc));
        check({tag, ".if_id"},  32'(hif.if_id_sel_o),  32'(a));
        check({tag, ".id_ex"},  32'(hif.id_ex_sel_o),  32'(b));
        check({tag, ".ex_mem"}, 32'(hif.ex_mem_sel_o), 32'(c));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        hif.id_rs1_addr_i  = '0;
        hif.id_rs2_addr_i  = '0;
        hif.id_rs1_used_i  = 1'b0;
        hif.id_rs2_used_i  = 1'b0;
        hif.id_rs1_f_i     = 1'b0;
        hif.id_rs2_f_i     = 1'b0;
        hif.ex_rd_addr_i   = '0;
        hif.ex_rd_wren_I_i = 1'b0;
        hif.ex_rd_wren_F_i = 1'b0;
        hif.ex_is_load_i   = 1'b0;
        hif.ex_br_taken_i  = 1'b0;
        hif.mem_req_i      = 1'b0;
        hif.mem_ack_i      = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic wr_i, input logic wr_f,
                          input logic [4:0] rs1, input logic u1, input logic f1,
                          input logic [4:0] rs2, input logic u2, input logic f2);
        hif.ex_is_load_i   = 1'b1;
        hif.ex_rd_addr_i   = rd;
        hif.ex_rd_wren_I_i = wr_i;
        hif.ex_rd_wren_F_i = wr_f;
        hif.id_rs1_addr_i  = rs1;
        hif.id_rs1_used_i  = u1;
        hif.id_rs1_f_i     = f1;
        hif.id_rs2_addr_i  = rs2;
        hif.id_rs2_used_i  = u2;
        hif.id_rs2_f_i     = f2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_clk   = 1'b0;
        i_rst   = 1'b1;
        idle();

        // Reset state
        tick();
        tick();
        @(negedge i_clk);
        check_ctrl("rst", 1'b0, SEL_CLEAR, SEL_CLEAR, SEL_CLEAR);
        check("rst.stall", stall_cnt, 32'd0);
        check("rst.flush", flush_cnt, 32'd0);
        check("rst.err", 32'(err_timeout), 32'd0);
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check_ctrl("idle", 1'b1, SEL_RUN, SEL_RUN, SEL_RUN);

        // lw x5 ; add x6,x5,x7
        tick();
        set_lu(5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        @(negedge i_clk);
        check_ctrl("lu_int", 1'b0, SEL_HOLD, SEL_CLEAR, SEL_RUN);
        tick();
        idle();
        @(negedge i_clk);
        check_ctrl("lu_after", 1'b1, SEL_RUN, SEL_RUN, SEL_RUN);
        check("lu.stall", stall_cnt, 32'd1);

        // lw x0 ; ID reads x0 via rs2
        tick();
        set_lu(5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        @(negedge i_clk);
        check("lu_x0.pc_en", 32'(hif.pc_en_o), 32'd1);

        // flw f0 ; fadd reads f0
        tick();
        set_lu(5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1);
        @(negedge i_clk);
        check_ctrl("lu_f0", 1'b0, SEL_HOLD, SEL_CLEAR, SEL_RUN);

        // integer x5 load vs FP f5 read
        tick();
        check("lu_f0.stall", stall_cnt, 32'd2);
        set_lu(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        @(negedge i_clk);
        check("lu_xf.pc_en", 32'(hif.pc_en_o), 32'd1);

        // matching address but source not read
        tick();
        set_lu(5'd9, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
        @(negedge i_clk);
        check("lu_unused.pc_en", 32'(hif.pc_en_o), 32'd1);

        // taken branch with coincident load-use
        tick();
        set_lu(5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
        hif.ex_br_taken_i = 1'b1;
        @(negedge i_clk);
        check_ctrl("br_lu", 1'b1, SEL_CLEAR, SEL_CLEAR, SEL_RUN);
        tick();
        idle();
        check("br.flush", flush_cnt, 32'd1);
        check("br.stall", stall_cnt, 32'd2);

        // MEM wait acked on 4th cycle; a branch during the wait is masked
        hif.mem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hif.ex_br_taken_i = (i == 1);
            @(negedge i_clk);
            check_ctrl($sformatf("mw%0d", i), 1'b0, SEL_HOLD, SEL_HOLD, SEL_HOLD);
            tick();
        end
        hif.ex_br_taken_i = 1'b0;
        hif.mem_ack_i     = 1'b1;
        @(negedge i_clk);
        check_ctrl("mw_ack", 1'b1, SEL_RUN, SEL_RUN, SEL_RUN);
        tick();
        idle();
        check("mw.stall", stall_cnt, 32'd5);
        check("mw.flush", flush_cnt, 32'd1);
        check("mw.err", 32'(err_timeout), 32'd0);
        check("mw.state", 32'(dut.state_q), 32'(S_RUN));

        // MEM wait with no ack: TIMEOUT-1 stall cycles then forced release
        hif.mem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check_ctrl($sformatf("to%0d", i), 1'b0, SEL_HOLD, SEL_HOLD, SEL_HOLD);
            tick();
        end
        @(negedge i_clk);
        check_ctrl("to_rel", 1'b1, SEL_RUN, SEL_RUN, SEL_RUN);
        tick();
        idle();
        check("to.err1", 32'(err_timeout), 32'd1);
        check("to.state", 32'(dut.state_q), 32'(S_RUN));
        check("to.stall", stall_cnt, 32'd8);
        tick();
        check("to.err0", 32'(err_timeout), 32'd0);

        // reset asserted while in S_WAIT
        hif.mem_req_i = 1'b1;
        tick();
        check("rw.state", 32'(dut.state_q), 32'(S_WAIT));
        i_rst = 1'b1;
        @(negedge i_clk);
        check_ctrl("rw_rst", 1'b0, SEL_CLEAR, SEL_CLEAR, SEL_CLEAR);
        tick();
        check("rw.state_after", 32'(dut.state_q), 32'(S_RUN));
        check("rw.stall", stall_cnt, 32'd0);
        check("rw.flush", flush_cnt, 32'd0);
        @(negedge i_clk);
        check_ctrl("rw_held", 1'b0, SEL_CLEAR, SEL_CLEAR, SEL_CLEAR);
        tick();
        i_rst = 1'b0;
        idle();

        // ack in the first request cycle: no stall
        hif.mem_req_i = 1'b1;
        hif.mem_ack_i = 1'b1;
        @(negedge i_clk);
        check_ctrl("ack1", 1'b1, SEL_RUN, SEL_RUN, SEL_RUN);
        tick();
        idle();
        check("ack1.state", 32'(dut.state_q), 32'(S_RUN));
        check("ack1.stall", stall_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
